// File: rtl/plot_pkg.sv
// Shared definitions for the plot datapath: command and state encodings,
// screen geometry and the command decoder.
package plot_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'b000,
    CMD_LOADX = 3'b001,
    CMD_PLOT  = 3'b100,
    CMD_BLACK = 3'b101
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADX = 3'd1,
    S_DRAW  = 3'd2,
    S_CLEAR = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [7:0] SCREEN_W  = 8'd160;
  localparam logic [7:0] SCREEN_H  = 8'd120;
  localparam logic [7:0] BLOCK_DIM = 8'd4;

  // Unknown command codes behave exactly like idle.
  function automatic cmd_t decode_cmd(input logic [2:0] raw);
    case (raw)
      3'b001:  return CMD_LOADX;
      3'b100:  return CMD_PLOT;
      3'b101:  return CMD_BLACK;
      default: return CMD_IDLE;
    endcase
  endfunction

  function automatic logic on_screen(input logic [7:0] x, input logic [7:0] y);
    return (x < SCREEN_W) && (y < SCREEN_H);
  endfunction

endpackage

// File: rtl/plot_datapath_xy_scan_counter.sv
// Nested x/y scan counter (x inner) with run-time last-value limits, shared by
// the block draw and the screen clear. Exposes its next value for registered decode.
module xy_scan_counter
  import plot_pkg::*;
(
  input  logic       clock,
  input  logic       ResetN,
  input  logic       start,
  input  logic       step,
  input  logic [7:0] x_last,
  input  logic [6:0] y_last,
  output logic [7:0] x_nxt,
  output logic [6:0] y_nxt,
  output logic       last
);

  logic [7:0] x_cnt_r;
  logic [6:0] y_cnt_r;

  assign last = (x_cnt_r == x_last) && (y_cnt_r == y_last);

  // Next count: restart, advance with x wrapping into y, or hold at the end.
  always_comb begin
    x_nxt = x_cnt_r;
    y_nxt = y_cnt_r;
    if (start) begin
      x_nxt = 8'd0;
      y_nxt = 7'd0;
    end else if (step && !last) begin
      if (x_cnt_r == x_last) begin
        x_nxt = 8'd0;
        y_nxt = y_cnt_r + 7'd1;
      end else begin
        x_nxt = x_cnt_r + 8'd1;
      end
    end else begin
      x_nxt = x_cnt_r;
    end
  end

  // Count registers.
  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      x_cnt_r <= 8'd0;
      y_cnt_r <= 7'd0;
    end else begin
      x_cnt_r <= x_nxt;
      y_cnt_r <= y_nxt;
    end
  end

endmodule

// File: rtl/plot_datapath.sv
// Plot datapath: loads X, draws a clipped pixel/block or clears the screen to black.
// Define PLOT_BLOCK_4X4_EN to draw a 4x4 block; otherwise a single pixel is drawn.
module plot_datapath
  import plot_pkg::*;
(
  input  logic       clock,
  input  logic       ResetN,
  input  logic [2:0] ctlCommand,
  input  logic [6:0] data_in,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       writeEn,
  output logic       done
);

`ifdef PLOT_BLOCK_4X4_EN
  localparam logic [7:0] DRAW_LAST = BLOCK_DIM - 8'd1;
`else
  localparam logic [7:0] DRAW_LAST = 8'd0;
`endif
  localparam logic [7:0] CLEAR_X_LAST = SCREEN_W - 8'd1;
  localparam logic [7:0] CLEAR_Y_LAST = SCREEN_H - 8'd1;

  cmd_t       cmd_s;
  state_t     state_r, state_nxt_s;
  cmd_t       start_cmd_r, start_cmd_nxt_s;
  logic [7:0] x_reg_r, x_nxt_s;
  logic [6:0] y_reg_r, y_nxt_s;
  logic [2:0] colour_reg_r, colour_nxt_s;
  logic       cnt_start_s, cnt_step_s, cnt_last_s;
  logic [7:0] cnt_x_nxt_s, x_lim_s, px_x_s;
  logic [6:0] cnt_y_nxt_s, y_lim_s;
  logic [7:0] px_y_s;
  logic [7:0] x_out_s;
  logic [6:0] y_out_s;
  logic [2:0] colour_out_s;
  logic       we_s, done_s;

  assign cmd_s   = decode_cmd(ctlCommand);
  assign x_lim_s = (state_r == S_CLEAR) ? CLEAR_X_LAST : DRAW_LAST;
  assign y_lim_s = (state_r == S_CLEAR) ? CLEAR_Y_LAST[6:0] : DRAW_LAST[6:0];

  xy_scan_counter u_scan (
    .clock  (clock),
    .ResetN (ResetN),
    .start  (cnt_start_s),
    .step   (cnt_step_s),
    .x_last (x_lim_s),
    .y_last (y_lim_s),
    .x_nxt  (cnt_x_nxt_s),
    .y_nxt  (cnt_y_nxt_s),
    .last   (cnt_last_s)
  );

  // State and operand registers.
  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r      <= S_IDLE;
      start_cmd_r  <= CMD_IDLE;
      x_reg_r      <= 8'd0;
      y_reg_r      <= 7'd0;
      colour_reg_r <= 3'd0;
    end else begin
      state_r      <= state_nxt_s;
      start_cmd_r  <= start_cmd_nxt_s;
      x_reg_r      <= x_nxt_s;
      y_reg_r      <= y_nxt_s;
      colour_reg_r <= colour_nxt_s;
    end
  end

  // Next state and operand updates; idle aborts everything, black beats an ongoing draw.
  always_comb begin
    state_nxt_s     = state_r;
    start_cmd_nxt_s = start_cmd_r;
    x_nxt_s         = x_reg_r;
    y_nxt_s         = y_reg_r;
    colour_nxt_s    = colour_reg_r;
    cnt_start_s     = 1'b0;
    cnt_step_s      = 1'b0;
    case (state_r)
      S_IDLE, S_LOADX, S_HOLD: begin
        if ((state_r != S_HOLD) || (cmd_s != start_cmd_r)) begin
          case (cmd_s)
            CMD_LOADX: begin
              state_nxt_s = S_LOADX;
              x_nxt_s     = {1'b0, data_in};
            end
            CMD_PLOT: begin
              state_nxt_s     = S_DRAW;
              start_cmd_nxt_s = CMD_PLOT;
              y_nxt_s         = data_in;
              colour_nxt_s    = colour_in;
              cnt_start_s     = 1'b1;
            end
            CMD_BLACK: begin
              state_nxt_s     = S_CLEAR;
              start_cmd_nxt_s = CMD_BLACK;
              cnt_start_s     = 1'b1;
            end
            default: begin
              state_nxt_s = S_IDLE;
              x_nxt_s     = 8'd0;
              y_nxt_s     = 7'd0;
            end
          endcase
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      S_DRAW: begin
        case (cmd_s)
          CMD_IDLE: begin
            state_nxt_s = S_IDLE;
            x_nxt_s     = 8'd0;
            y_nxt_s     = 7'd0;
          end
          CMD_BLACK: begin
            state_nxt_s     = S_CLEAR;
            start_cmd_nxt_s = CMD_BLACK;
            cnt_start_s     = 1'b1;
          end
          default: begin
            if (cnt_last_s) begin
              state_nxt_s = S_HOLD;
            end else begin
              cnt_step_s = 1'b1;
            end
          end
        endcase
      end
      S_CLEAR: begin
        case (cmd_s)
          CMD_IDLE: begin
            state_nxt_s = S_IDLE;
            x_nxt_s     = 8'd0;
            y_nxt_s     = 7'd0;
          end
          default: begin
            if (cnt_last_s) begin
              state_nxt_s = S_HOLD;
            end else begin
              cnt_step_s = 1'b1;
            end
          end
        endcase
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Pixel address is formed at 8 bits so off-screen rows are seen before truncation.
  assign px_x_s = x_nxt_s + cnt_x_nxt_s;
  assign px_y_s = {1'b0, y_nxt_s} + {1'b0, cnt_y_nxt_s};

  // Output decode from the values about to be registered.
  always_comb begin
    we_s         = 1'b0;
    done_s       = 1'b0;
    x_out_s      = 8'd0;
    y_out_s      = 7'd0;
    colour_out_s = 3'd0;
    case (state_nxt_s)
      S_DRAW: begin
        we_s         = on_screen(px_x_s, px_y_s);
        x_out_s      = px_x_s;
        y_out_s      = px_y_s[6:0];
        colour_out_s = colour_nxt_s;
      end
      S_CLEAR: begin
        we_s    = 1'b1;
        x_out_s = cnt_x_nxt_s;
        y_out_s = cnt_y_nxt_s;
      end
      S_HOLD: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Registered VGA-side outputs.
  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      x_out      <= 8'd0;
      y_out      <= 7'd0;
      colour_out <= 3'd0;
      writeEn    <= 1'b0;
      done       <= 1'b0;
    end else begin
      x_out      <= x_out_s;
      y_out      <= y_out_s;
      colour_out <= colour_out_s;
      writeEn    <= we_s;
      done       <= done_s;
    end
  end

endmodule
